// File: rtl/pwm_duty_ramp.sv
// pwm_duty_ramp: period/duty setpoint controller feeding a pwm block.
// A one-deep shadow takes new {max, duty, step} settings over a valid/ready
// handshake. The period is changed only at a period boundary (tick), and the
// duty slews toward its target by one step per period.
module pwm_duty_ramp #(
  parameter int NB       = 32,
  parameter int INIT_MAX = 10
) (
  input  logic          clk,
  input  logic          i_reset,
  input  logic          i_enable,
  input  logic          i_cfg_valid,
  output logic          o_cfg_ready,
  input  logic [NB-1:0] i_cfg_max,
  input  logic [NB-1:0] i_cfg_duty,
  input  logic [NB-1:0] i_cfg_step,
  output logic [NB-1:0] o_max_counter,
  output logic [NB-1:0] o_max_duty,
  output logic          o_tick,
  output logic          o_busy,
  output logic          o_done
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HOLD,
    ST_RAMP_UP,
    ST_RAMP_DOWN
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic          r_pending;
  logic [NB-1:0] r_sh_max;
  logic [NB-1:0] r_sh_duty;
  logic [NB-1:0] r_sh_step;
  logic [NB-1:0] r_cnt;
  logic [NB-1:0] r_max;
  logic [NB-1:0] r_duty;
  logic [NB-1:0] r_target;
  logic [NB-1:0] r_step;
  logic          r_done;

  logic          w_tick;
  logic          w_accept;
  logic          w_idle_apply;
  logic          w_apply;
  logic          w_ramp;
  logic          w_update;
  logic [NB-1:0] w_sh_target;
  logic [NB-1:0] w_max_nxt;
  logic [NB-1:0] w_duty_nxt;
  logic [NB-1:0] w_target_nxt;
  logic [NB-1:0] w_step_nxt;
  logic [NB:0]   w_diff;

  // Period boundary: last count of the period, or every cycle for tiny periods.
  assign w_tick       = i_enable && ((r_max <= NB'(1)) || (r_cnt >= r_max - NB'(1)));
  assign w_accept     = i_cfg_valid && !r_pending;
  // A pending config with the block disabled applies on the next edge as a jump.
  assign w_idle_apply = r_pending && !i_enable && (r_state == ST_IDLE);
  assign w_apply      = r_pending && (w_tick || w_idle_apply);
  // The ramp step never runs on an apply tick; pending holds it off.
  assign w_ramp       = w_tick && !r_pending;
  assign w_update     = w_apply || w_ramp;
  assign w_sh_target  = (r_sh_duty > r_sh_max) ? r_sh_max : r_sh_duty;

  // Next period/target/step/duty for the apply and ramp paths.
  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    w_max_nxt    = r_max;
    w_duty_nxt   = r_duty;
    w_target_nxt = r_target;
    w_step_nxt   = r_step;
    w_diff       = '0;
    if (w_apply) begin
      w_max_nxt    = r_sh_max;
      w_target_nxt = w_sh_target;
      w_step_nxt   = r_sh_step;
      if (w_idle_apply)
        w_duty_nxt = w_sh_target;
      else if (r_duty > r_sh_max)
        w_duty_nxt = r_sh_max;
    end else if (w_ramp) begin
      // Distance is taken in NB+1 bits so the step test never wraps or overshoots.
      case (r_state)
        ST_RAMP_UP: begin
          w_diff = {1'b0, r_target} - {1'b0, r_duty};
          if ((r_step == '0) || (w_diff <= {1'b0, r_step}))
            w_duty_nxt = r_target;
          else
            w_duty_nxt = r_duty + r_step;
        end
        ST_RAMP_DOWN: begin
          w_diff = {1'b0, r_duty} - {1'b0, r_target};
          if ((r_step == '0) || (w_diff <= {1'b0, r_step}))
            w_duty_nxt = r_target;
          else
            w_duty_nxt = r_duty - r_step;
        end
        default: ;
      endcase
    end
  end

  // Next state follows the post-update duty/target relation, so busy drops with done.
  always_comb begin
    w_state_nxt = r_state;
    if (!i_enable)
      w_state_nxt = ST_IDLE;
    else if (w_duty_nxt < w_target_nxt)
      w_state_nxt = ST_RAMP_UP;
    else if (w_duty_nxt > w_target_nxt)
      w_state_nxt = ST_RAMP_DOWN;
    else
      w_state_nxt = ST_HOLD;
  end

  // State register.
  always_ff @(posedge clk or negedge i_reset) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (!i_reset) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Shadow register and pending flag; reset discards any queued config.
  always_ff @(posedge clk or negedge i_reset) begin
    if (!i_reset) begin
      r_pending <= 1'b0;
      r_sh_max  <= '0;
      r_sh_duty <= '0;
      r_sh_step <= '0;
    end else if (w_accept) begin
      r_pending <= 1'b1;
      r_sh_max  <= i_cfg_max;
      r_sh_duty <= i_cfg_duty;
      r_sh_step <= i_cfg_step;
    end else if (w_apply) begin
      r_pending <= 1'b0;
    end
  end

  // Period counter: runs while enabled, wraps at the tick, parks at 0 when disabled.
  always_ff @(posedge clk or negedge i_reset) begin
    if (!i_reset)                r_cnt <= '0;
    else if (!i_enable || w_tick) r_cnt <= '0;
    else                         r_cnt <= r_cnt + NB'(1);
  end

  // Setpoint registers and done strobe; done only when duty moves onto the target.
  always_ff @(posedge clk or negedge i_reset) begin
    if (!i_reset) begin
      r_max    <= NB'(INIT_MAX);
      r_duty   <= '0;
      r_target <= '0;
      r_step   <= '0;
      r_done   <= 1'b0;
    end else begin
      r_max    <= w_max_nxt;
      r_duty   <= w_duty_nxt;
      r_target <= w_target_nxt;
      r_step   <= w_step_nxt;
      r_done   <= w_update && (w_duty_nxt == w_target_nxt) && (w_duty_nxt != r_duty);
    end
  end

  assign o_cfg_ready   = !r_pending;
  assign o_max_counter = r_max;
  assign o_max_duty    = r_duty;
  assign o_tick        = w_tick;
  assign o_busy        = r_pending || (r_state == ST_RAMP_UP) || (r_state == ST_RAMP_DOWN);
  assign o_done        = r_done;

endmodule

// File: tb/tb_pwm_duty_ramp.sv
// Directed bench for pwm_duty_ramp: inputs change and outputs are sampled on
// the falling clock edge, away from the rising edge the design uses.
module tb_pwm_duty_ramp;
  localparam int NB = 32;

  logic          clk = 1'b0;
  logic          i_reset;
  logic          i_enable;
  logic          i_cfg_valid;
  logic          o_cfg_ready;
  logic [NB-1:0] i_cfg_max;
  logic [NB-1:0] i_cfg_duty;
  logic [NB-1:0] i_cfg_step;
  logic [NB-1:0] o_max_counter;
  logic [NB-1:0] o_max_duty;
  logic          o_tick;
  logic          o_busy;
  logic          o_done;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pwm_duty_ramp #(.NB(NB), .INIT_MAX(10)) dut (
    .clk          (clk),
    .i_reset      (i_reset),
    .i_enable     (i_enable),
    .i_cfg_valid  (i_cfg_valid),
    .o_cfg_ready  (o_cfg_ready),
    .i_cfg_max    (i_cfg_max),
    .i_cfg_duty   (i_cfg_duty),
    .i_cfg_step   (i_cfg_step),
    .o_max_counter(o_max_counter),
    .o_max_duty   (o_max_duty),
    .o_tick       (o_tick),
    .o_busy       (o_busy),
    .o_done       (o_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic offer(input int m, input int d, input int s);
    i_cfg_max   = NB'(m);
    i_cfg_duty  = NB'(d);
    i_cfg_step  = NB'(s);
    i_cfg_valid = 1'b1;
  endtask

  // Advance until o_tick is seen (bounded) and check how many cycles it took.
  task automatic wait_tick(input int gap, input string tag);
    int n;
    n = 0;
    do begin
      cyc();
      n++;
    end while (!o_tick && n < 100);
    chk(tag, n, gap);
  endtask

  // Step past the tick edge and check the values it produced.
  task automatic after_tick(input int duty, input int done, input int busy, input int max,
                            input string tag);
    cyc();
    chk({tag, "_duty"}, o_max_duty, duty);
    chk({tag, "_done"}, {31'd0, o_done}, done);
    chk({tag, "_busy"}, {31'd0, o_busy}, busy);
    chk({tag, "_max"},  o_max_counter, max);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_max"},   o_max_counter, 10);
    chk({tag, "_duty"},  o_max_duty, 0);
    chk({tag, "_ready"}, {31'd0, o_cfg_ready}, 1);
    chk({tag, "_tick"},  {31'd0, o_tick}, 0);
    chk({tag, "_busy"},  {31'd0, o_busy}, 0);
    chk({tag, "_done"},  {31'd0, o_done}, 0);
  endtask

  initial begin
    i_reset     = 1'b0;
    i_enable    = 1'b0;
    i_cfg_valid = 1'b0;
    i_cfg_max   = '0;
    i_cfg_duty  = '0;
    i_cfg_step  = '0;

    // Reset state.
    repeat (3) cyc();
    chk_reset("rst");
    i_reset = 1'b1;
    cyc();

    // Ramp up 0 -> 8 in steps of 3; apply at the first tick leaves duty at 0.
    i_enable = 1'b1;
    offer(10, 8, 3);
    cyc();
    i_cfg_valid = 1'b0;
    chk("up_ready_low", {31'd0, o_cfg_ready}, 0);
    chk("up_busy_pend", {31'd0, o_busy}, 1);
    wait_tick(8, "up_gap0");
    after_tick(0, 0, 1, 10, "up_apply");
    chk("up_ready_back", {31'd0, o_cfg_ready}, 1);
    wait_tick(9, "up_gap1");
    after_tick(3, 0, 1, 10, "up_s1");
    wait_tick(9, "up_gap2");
    after_tick(6, 0, 1, 10, "up_s2");
    wait_tick(9, "up_gap3");
    after_tick(8, 1, 0, 10, "up_s3");
    cyc();
    chk("up_done_1cyc", {31'd0, o_done}, 0);

    // Ramp down 8 -> 1 in steps of 2: 6, 4, 2, 1.
    offer(10, 1, 2);
    cyc();
    i_cfg_valid = 1'b0;
    wait_tick(7, "dn_gap0");
    after_tick(8, 0, 1, 10, "dn_apply");
    wait_tick(9, "dn_gap1");
    after_tick(6, 0, 1, 10, "dn_s1");
    wait_tick(9, "dn_gap2");
    after_tick(4, 0, 1, 10, "dn_s2");
    wait_tick(9, "dn_gap3");
    after_tick(2, 0, 1, 10, "dn_s3");
    wait_tick(9, "dn_gap4");
    after_tick(1, 1, 0, 10, "dn_s4");
    cyc();
    chk("dn_done_1cyc", {31'd0, o_done}, 0);

    // Jump (step 0) with a second config offered right behind it.
    offer(10, 5, 0);
    cyc();
    offer(12, 5, 0);
    chk("bp_ready_low", {31'd0, o_cfg_ready}, 0);
    wait_tick(7, "bp_gap0");
    chk("bp_ready_at_tick", {31'd0, o_cfg_ready}, 0);
    after_tick(1, 0, 1, 10, "bp_apply1");
    chk("bp_ready_free", {31'd0, o_cfg_ready}, 1);
    cyc();
    i_cfg_valid = 1'b0;
    chk("bp_second_taken", {31'd0, o_cfg_ready}, 0);
    wait_tick(8, "bp_gap1");
    after_tick(1, 0, 1, 12, "bp_apply2");
    wait_tick(11, "bp_gap2");
    after_tick(5, 1, 0, 12, "bp_jump");
    cyc();
    chk("bp_done_1cyc", {31'd0, o_done}, 0);

    // Disabled apply: config lands one cycle after capture as a jump, no ticks.
    i_enable = 1'b0;
    cyc();
    offer(6, 3, 1);
    chk("dis_tick0", {31'd0, o_tick}, 0);
    cyc();
    i_cfg_valid = 1'b0;
    chk("dis_max_pend", o_max_counter, 12);
    chk("dis_duty_pend", o_max_duty, 5);
    chk("dis_busy_pend", {31'd0, o_busy}, 1);
    cyc();
    chk("dis_max", o_max_counter, 6);
    chk("dis_duty", o_max_duty, 3);
    chk("dis_done", {31'd0, o_done}, 1);
    chk("dis_busy", {31'd0, o_busy}, 0);
    chk("dis_ready", {31'd0, o_cfg_ready}, 1);
    cyc();
    chk("dis_done_1cyc", {31'd0, o_done}, 0);
    for (int i = 0; i < 6; i++) begin
      chk("dis_no_tick", {31'd0, o_tick}, 0);
      cyc();
    end

    // Preload duty 8 while disabled, then shrink the period to 4 with target 6.
    offer(10, 8, 0);
    cyc();
    i_cfg_valid = 1'b0;
    cyc();
    chk("pre_max", o_max_counter, 10);
    chk("pre_duty", o_max_duty, 8);
    i_enable = 1'b1;
    offer(4, 6, 1);
    cyc();
    i_cfg_valid = 1'b0;
    wait_tick(8, "sh_gap0");
    after_tick(4, 1, 0, 4, "sh_apply");
    wait_tick(3, "sh_gap1");
    after_tick(4, 0, 0, 4, "sh_hold");

    // Start a long ramp, queue another config, then reset asynchronously mid-ramp.
    offer(20, 20, 1);
    cyc();
    i_cfg_valid = 1'b0;
    wait_tick(2, "mr_gap0");
    after_tick(4, 0, 1, 20, "mr_apply");
    wait_tick(19, "mr_gap1");
    after_tick(5, 0, 1, 20, "mr_s1");
    offer(7, 7, 0);
    cyc();
    i_cfg_valid = 1'b0;
    chk("mr_pend", {31'd0, o_cfg_ready}, 0);
    #2 i_reset = 1'b0;
    #1 chk_reset("mr_rst");
    cyc();
    i_reset = 1'b1;
    repeat (2) cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
